// File: rtl/teclado_scanner.sv
// 4x4 keypad scanner with debounce and encoding into the tecla/tipo code pair.
// Define TECLADO_HEX_EN to turn the * key into a hex-shift toggle (modo_hex).
module teclado_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] columnas,
  output logic [3:0] fila,
  output logic [3:0] tecla,
  output logic       tipo,
  output logic       valido,
  output logic       ocupado,
  output logic       modo_hex
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, HOLD, RELEASE} state_t;

  state_t          state;
  logic [3:0]      col_meta;
  logic [3:0]      cs;
  logic [1:0]      row;
  logic [1:0]      cap_col;
  logic [DW-1:0]   dwell;
  logic [CW-1:0]   cnt;
  logic            col_low;
  logic [4:0]      code;

  function automatic logic [3:0] drive(input logic [1:0] r);
    drive = ~(4'b0001 << r);
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    if (!c[0])      lowest_low = 2'd0;
    else if (!c[1]) lowest_low = 2'd1;
    else if (!c[2]) lowest_low = 2'd2;
    else            lowest_low = 2'd3;
  endfunction

  // Returns {tipo, tecla} for the key at (r, c); hex only affects A..D and #.
  function automatic logic [4:0] encode(input logic [1:0] r, input logic [1:0] c,
                                        input logic hex);
    case ({r, c})
      4'd0:    encode = 5'h11;
      4'd1:    encode = 5'h12;
      4'd2:    encode = 5'h13;
      4'd3:    encode = hex ? 5'h1A : 5'h00;
      4'd4:    encode = 5'h14;
      4'd5:    encode = 5'h15;
      4'd6:    encode = 5'h16;
      4'd7:    encode = hex ? 5'h1B : 5'h01;
      4'd8:    encode = 5'h17;
      4'd9:    encode = 5'h18;
      4'd10:   encode = 5'h19;
      4'd11:   encode = hex ? 5'h1C : 5'h02;
      4'd12:   encode = 5'h04;
      4'd13:   encode = 5'h10;
      4'd14:   encode = hex ? 5'h1E : 5'h06;
      default: encode = hex ? 5'h1D : 5'h03;
    endcase
  endfunction

  assign col_low = ~cs[cap_col];
  assign code    = encode(row, cap_col, modo_hex);

`ifndef TECLADO_HEX_EN
  assign modo_hex = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      cs       <= 4'hF;
      state    <= SCAN;
      row      <= 2'd0;
      cap_col  <= 2'd0;
      dwell    <= '0;
      cnt      <= '0;
      fila     <= 4'b1110;
      tecla    <= 4'h0;
      tipo     <= 1'b0;
      valido   <= 1'b0;
      ocupado  <= 1'b0;
`ifdef TECLADO_HEX_EN
      modo_hex <= 1'b0;
`endif
    end else begin
      col_meta <= columnas;
      cs       <= col_meta;
      valido   <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (cs != 4'hF) begin
              cap_col <= lowest_low(cs);
              ocupado <= 1'b1;
              cnt     <= '0;
              state   <= DEBOUNCE;
            end else begin
              row  <= row + 2'd1;
              fila <= drive(row + 2'd1);
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        DEBOUNCE: begin
          // Row stays frozen here, so row is also the captured row.
          if (!col_low) begin
            ocupado <= 1'b0;
            cnt     <= '0;
            row     <= row + 2'd1;
            fila    <= drive(row + 2'd1);
            state   <= SCAN;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= EMIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        EMIT: begin
          state <= HOLD;
`ifdef TECLADO_HEX_EN
          if ({row, cap_col} == 4'd12) begin
            modo_hex <= ~modo_hex;
          end else begin
            {tipo, tecla} <= code;
            valido        <= 1'b1;
          end
`else
          {tipo, tecla} <= code;
          valido        <= 1'b1;
`endif
        end
        HOLD: begin
          if (!col_low) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (col_low) begin
            state <= HOLD;
          end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            ocupado <= 1'b0;
            row     <= row + 2'd1;
            fila    <= drive(row + 2'd1);
            state   <= SCAN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_teclado_scanner.sv
// Self-checking bench for teclado_scanner: keypad matrix model plus key-level reference model.
module tb_teclado_scanner;
  localparam int SD = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  columnas;
  logic [3:0]  fila;
  logic [3:0]  tecla;
  logic        tipo;
  logic        valido;
  logic        ocupado;
  logic        modo_hex;
  logic [15:0] pressed = 16'h0;

  int    checks = 0;
  int    errors = 0;
  int    vtotal = 0;
  bit    model_hex = 1'b0;
  string layout = "123A456B789C*0#D";

  teclado_scanner #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .columnas(columnas), .fila(fila), .tecla(tecla),
    .tipo(tipo), .valido(valido), .ocupado(ocupado), .modo_hex(modo_hex)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    columnas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!fila[r] && pressed[r*4+c]) columnas[c] = 1'b0;
  end

  always @(negedge clk) if (valido === 1'b1) vtotal++;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] row_pat(input int r);
    row_pat = ~(4'b0001 << r);
  endfunction

  // Reference: which key sits where, and what it should emit.
  function automatic bit model_emit(input int k, input bit hex, output logic [4:0] code);
    byte ch;
    ch   = layout[k];
    code = 5'h0;
    if (ch >= "0" && ch <= "9") begin
      code = {1'b1, 4'(ch - "0")};
      return 1'b1;
    end
    if (ch >= "A" && ch <= "D") begin
      code = hex ? {1'b1, 4'(10 + ch - "A")} : {1'b0, 4'(ch - "A")};
      return 1'b1;
    end
    if (ch == "#") begin
      code = hex ? 5'h1E : 5'h06;
      return 1'b1;
    end
`ifdef TECLADO_HEX_EN
    return 1'b0;
`else
    code = 5'h04;
    return 1'b1;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fila"}, fila, 4'b1110);
    chk({tag, "_tecla"}, tecla, 4'h0);
    chk({tag, "_tipo"}, tipo, 1'b0);
    chk({tag, "_valido"}, valido, 1'b0);
    chk({tag, "_ocupado"}, ocupado, 1'b0);
    chk({tag, "_modo_hex"}, modo_hex, 1'b0);
  endtask

  task automatic wait_ocupado(input logic lvl, input int budget, output int n);
    n = 0;
    while (ocupado !== lvl && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic press(input int k, input int hold, input bit bounce);
    int n;
    int v0;
    bit emits;
    logic [4:0] exp;
    v0    = vtotal;
    emits = model_emit(k, model_hex, exp);
    pressed[k] = 1'b1;
    wait_ocupado(1'b1, 40, n);
    chk("capture", ocupado, 1'b1);
    chk("fila_frozen", fila, row_pat(k / 4));
    if (emits) begin
      n = 0;
      while (valido !== 1'b1 && n < 30) begin
        step();
        n++;
      end
      chk("latency", n, DB + 1);
      chk("code", {tipo, tecla}, exp);
    end else begin
      repeat (DB + 3) step();
      model_hex = !model_hex;
    end
    repeat (hold) step();
    chk("ocupado_hold", ocupado, 1'b1);
    pressed[k] = 1'b0;
    if (bounce) begin
      repeat (4) step();
      pressed[k] = 1'b1;
      repeat (3) step();
      pressed[k] = 1'b0;
    end
    wait_ocupado(1'b0, 60, n);
    if (!bounce) chk("release_time", (n >= DB + 1 && n <= DB + 4), 1);
    chk("ocupado_low", ocupado, 1'b0);
    chk("fila_next", fila, row_pat((k / 4 + 1) % 4));
    chk("strobes", vtotal - v0, emits ? 1 : 0);
    chk("modo_hex", modo_hex, model_hex);
    $display("press key=%s hold=%0d bounce=%0d tecla=%h tipo=%b modo_hex=%b strobes=%0d",
             layout.substr(k, k), hold, bounce, tecla, tipo, modo_hex, vtotal - v0);
    repeat (3) step();
  endtask

  initial begin
    int n;
    int k;
    int v0;
    logic [4:0] exp;
    bit emits;

    // Reset and idle scan.
    rst_n = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    v0 = vtotal;
    for (int j = 0; j < 20; j++) begin
      chk("idle_fila", fila, row_pat((j / SD) % 4));
      if (j != 19) step();
    end
    chk("idle_strobes", vtotal - v0, 0);
    chk("idle_ocupado", ocupado, 1'b0);
    $display("idle scan 20 cycles fila=%b", fila);

    // Directed keys: 6, #, D, *, then B and * again (hex toggle when enabled).
    press(6, 40, 1'b0);
    press(14, 5, 1'b0);
    press(15, 5, 1'b0);
    press(12, 5, 1'b0);
    press(7, 5, 1'b0);
    press(12, 5, 1'b0);

    // Random keys, some with release bounce.
    for (int i = 0; i < 8; i++)
      press($urandom_range(0, 15), $urandom_range(2, 30), 1'($urandom_range(0, 1)));

    // Glitch during debounce: rejected, scan resumes on the next row.
    k  = $urandom_range(0, 15);
    v0 = vtotal;
    pressed[k] = 1'b1;
    wait_ocupado(1'b1, 40, n);
    chk("glitch_capture", ocupado, 1'b1);
    repeat (3) step();
    pressed[k] = 1'b0;
    wait_ocupado(1'b0, 20, n);
    chk("glitch_ocupado", ocupado, 1'b0);
    chk("glitch_fila", fila, row_pat((k / 4 + 1) % 4));
    repeat (DB + 4) step();
    chk("glitch_strobes", vtotal - v0, 0);
    $display("glitch key=%s strobes=%0d", layout.substr(k, k), vtotal - v0);

    // Reset mid-debounce, key kept held: fresh full debounce after reset.
    do k = $urandom_range(0, 15); while (k == 12);
    pressed[k] = 1'b1;
    wait_ocupado(1'b1, 40, n);
    repeat (2) step();
    v0 = vtotal;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_hex = 1'b0;
    step();
    chk("midreset_strobes", vtotal - v0, 0);
    rst_n = 1'b1;
    n = 0;
    while (valido !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    chk("postreset_latency", n, SD * (k / 4 + 1) + DB + 1);
    emits = model_emit(k, model_hex, exp);
    chk("postreset_code", {tipo, tecla}, exp);
    pressed[k] = 1'b0;
    wait_ocupado(1'b0, 40, n);
    chk("postreset_release", ocupado, 1'b0);
    chk("postreset_strobes", vtotal - v0, emits ? 1 : 0);
    $display("reset mid-debounce key=%s tecla=%h tipo=%b", layout.substr(k, k), tecla, tipo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
